// File: rtl/stream_window_3x3.sv
// stream_window_3x3: raster 8-bit pixel stream -> registered 3x3 signed window via two line buffers.
// Optional STREAM_WINDOW_POS_EN adds center_col/center_row outputs.
module stream_window_3x3 #(
    parameter int PRECISION = 16,
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  pixel_in,
    input  logic                        pixel_valid,
    input  logic                        frame_start,
    output logic signed [PRECISION-1:0] buffer_3 [2:0][2:0],
    output logic                        window_valid,
    output logic                        frame_done
`ifdef STREAM_WINDOW_POS_EN
    ,
    output logic [$clog2(WIDTH)-1:0]    center_col,
    output logic [$clog2(HEIGHT)-1:0]   center_row
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    logic [CW-1:0] col, pcol;
    logic [RW-1:0] row, prow;
    logic [7:0]    line_a [WIDTH];
    logic [7:0]    line_b [WIDTH];
    logic [7:0]    a, b;
    logic          accept, last_col, last_row;
    // frame_start forces the accepted pixel to (0,0) regardless of the counters
    always_comb begin
        accept   = pixel_valid && !reset;
        pcol     = frame_start ? '0 : col;
        prow     = frame_start ? '0 : row;
        a        = line_a[pcol];
        b        = line_b[pcol];
        last_col = pcol == CW'(WIDTH - 1);
        last_row = prow == RW'(HEIGHT - 1);
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            line_a[pcol] <= b;
            line_b[pcol] <= pixel_in;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    buffer_3[r][c] <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            col          <= '0;
            row          <= '0;
        end else begin
            window_valid <= accept && prow >= RW'(2) && pcol >= CW'(2);
            frame_done   <= accept && last_col && last_row;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    buffer_3[r][0] <= buffer_3[r][1];
                    buffer_3[r][1] <= buffer_3[r][2];
                end
                buffer_3[0][2] <= $signed(PRECISION'(a));
                buffer_3[1][2] <= $signed(PRECISION'(b));
                buffer_3[2][2] <= $signed(PRECISION'(pixel_in));
                col <= last_col ? '0 : pcol + 1'b1;
                row <= last_col ? (last_row ? '0 : prow + 1'b1) : prow;
            end
        end
    end
`ifdef STREAM_WINDOW_POS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            center_col <= '0;
            center_row <= '0;
        end else if (accept) begin
            center_col <= pcol - 1'b1;
            center_row <= prow - 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_stream_window_3x3.sv
// tb_stream_window_3x3: randomized and directed stimulus checked against an image-array reference model.
module tb_stream_window_3x3;
    localparam int W = 4;
    localparam int H = 4;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        pixel_in = '0;
    logic              pixel_valid = 1'b0;
    logic              frame_start = 1'b0;
    logic signed [15:0] buffer_3 [2:0][2:0];
    logic              window_valid;
    logic              frame_done;
`ifdef STREAM_WINDOW_POS_EN
    logic [1:0]        center_col;
    logic [1:0]        center_row;
`endif
    int img [H][W];
    int mrow = 0;
    int mcol = 0;
    int checks = 0;
    int fails = 0;
    int pulses = 0;

    stream_window_3x3 #(.PRECISION(16), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk),
        .reset(reset),
        .pixel_in(pixel_in),
        .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .buffer_3(buffer_3),
        .window_valid(window_valid),
        .frame_done(frame_done)
`ifdef STREAM_WINDOW_POS_EN
        ,
        .center_col(center_col),
        .center_row(center_row)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: remember every accepted pixel at its (row,col); a valid window is the 3x3 block ending there.
    task automatic send(input logic [7:0] p, input bit fs);
        int  y, x;
        bit  ev, efd;
        y = fs ? 0 : mrow;
        x = fs ? 0 : mcol;
        img[y][x] = p;
        ev  = y >= 2 && x >= 2;
        efd = y == H - 1 && x == W - 1;
        if (x == W - 1) begin
            mcol = 0;
            mrow = (y == H - 1) ? 0 : y + 1;
        end else begin
            mcol = x + 1;
            mrow = y;
        end
        pixel_in = p;
        pixel_valid = 1'b1;
        frame_start = fs;
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        check("window_valid", window_valid, ev);
        check("frame_done", frame_done, efd);
        check("newest_pixel", buffer_3[2][2], p);
        if (ev) begin
            pulses++;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    check($sformatf("win[%0d][%0d]@(%0d,%0d)", r, c, y, x), buffer_3[r][c], img[y-2+r][x-2+c]);
`ifdef STREAM_WINDOW_POS_EN
            check("center_col", center_col, x - 1);
            check("center_row", center_row, y - 1);
`endif
        end
    endtask

    task automatic idle();
        logic signed [15:0] snap [2:0][2:0];
        snap = buffer_3;
        pixel_valid = 1'b0;
        frame_start = 1'($urandom_range(0, 1));
        pixel_in = 8'($urandom);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        check("gap_window_valid", window_valid, 0);
        check("gap_frame_done", frame_done, 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check($sformatf("gap_hold[%0d][%0d]", r, c), buffer_3[r][c], snap[r][c]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pixel_valid = 1'($urandom_range(0, 1));
        frame_start = 1'($urandom_range(0, 1));
        pixel_in = 8'($urandom);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        mrow = 0;
        mcol = 0;
        check("rst_window_valid", window_valid, 0);
        check("rst_frame_done", frame_done, 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check($sformatf("rst_buf[%0d][%0d]", r, c), buffer_3[r][c], 0);
    endtask

    task automatic frame(input int base, input bit gaps, input bit fs, input int p00);
        pulses = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                send(8'((y == 0 && x == 0) ? p00 : base + 16 * y + x), fs && y == 0 && x == 0);
                if (gaps) idle();
            end
        check("pulses_per_frame", pulses, 4);
    endtask

    initial begin
        do_reset();
        do_reset();
        frame(0, 0, 1, 0);
        frame(0, 1, 1, 0);
        frame(100, 0, 1, 100);
        frame(0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            send(8'(16 * (i / 4) + (i % 4)), i == 0);
        frame(0, 0, 1, 0);
        for (int i = 0; i < 13; i++)
            send(8'(16 * (i / 4) + (i % 4)), i == 0);
        do_reset();
        frame(0, 0, 0, 255);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else send(8'($urandom), $urandom_range(0, 29) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
